// File: rtl/attn_pkg.sv
// Shared attention-pipeline types, default widths and fixed-point helpers.
// Used by the score, softmax and context stages.
package attn_pkg;

   localparam int unsigned DefDataWidth = 16;
   localparam int unsigned DefEmbedDim  = 64;
   localparam int unsigned DefFracBits  = 14;
   localparam int unsigned AccWidth     = 2 * DefDataWidth + $clog2(DefEmbedDim);

   typedef enum logic [2:0] {
      StIdle,
      StWaitK,
      StMac,
      StOut,
      StDone
   } qk_state_t;

   // Arithmetic right shift (floor) followed by clamp to a signed DefDataWidth value.
   function automatic logic [DefDataWidth-1:0] sat_shift(input logic signed [AccWidth-1:0] acc,
                                                         input int unsigned shift);
      logic signed [AccWidth-1:0] sh;
      logic signed [AccWidth-1:0] sat_max;
      logic signed [AccWidth-1:0] sat_min;
      sat_max = {{(AccWidth - DefDataWidth + 1){1'b0}}, {(DefDataWidth - 1){1'b1}}};
      sat_min = {{(AccWidth - DefDataWidth + 1){1'b1}}, {(DefDataWidth - 1){1'b0}}};
      sh      = acc >>> shift;
      if (sh > sat_max) begin
         sat_shift = sat_max[DefDataWidth-1:0];
      end else if (sh < sat_min) begin
         sat_shift = sat_min[DefDataWidth-1:0];
      end else begin
         sat_shift = sh[DefDataWidth-1:0];
      end
   endfunction

endpackage

// File: rtl/fx_mac.sv
// Signed multiply-accumulate register: acc += a*b with full-precision product.
module fx_mac #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = 38
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_WIDTH-1:0]  acc
);

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    prod_ext;

   assign prod     = a * b;
   assign prod_ext = {{(ACC_WIDTH - 2 * DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/qk_score.sv
// Scaled Q.K attention score: latches one query, then emits one saturated score per key
// using a single serial MAC.
module qk_score
   import attn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DefDataWidth,
   parameter int unsigned EMBED_DIM   = DefEmbedDim,
   parameter int unsigned FRAC_BITS   = DefFracBits,
   parameter int unsigned SEQ_LEN     = 8,
   parameter int unsigned SCALE_SHIFT = 3,
   localparam int unsigned IDX_W      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
   localparam int unsigned VEC_W      = DATA_WIDTH * EMBED_DIM
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [VEC_W-1:0]      q_flat,
   input  logic                  k_valid,
   output logic                  k_ready,
   input  logic [VEC_W-1:0]      k_flat,
   output logic                  score_valid,
   input  logic                  score_ready,
   output logic [DATA_WIDTH-1:0] score,
   output logic [IDX_W-1:0]      score_idx,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned ACC_W  = 2 * DATA_WIDTH + $clog2(EMBED_DIM);
   localparam int unsigned ELEM_W = $clog2(EMBED_DIM);
   localparam int unsigned CNT_W  = ELEM_W + 1;
   // The counter runs one past the last element so the final accumulate settles before OUT.
   localparam logic [CNT_W-1:0] MacEnd  = CNT_W'(EMBED_DIM);
   localparam logic [IDX_W-1:0] LastKey = IDX_W'(SEQ_LEN - 1);

   qk_state_t state_q, state_d;

   logic [VEC_W-1:0]             q_q;
   logic [VEC_W-1:0]             k_q;
   logic [CNT_W-1:0]             elem_cnt;
   logic [ELEM_W-1:0]            elem_idx;
   logic [IDX_W-1:0]             key_cnt;
   logic                         k_fire;
   logic                         mac_en;
   logic signed [DATA_WIDTH-1:0] q_elem;
   logic signed [DATA_WIDTH-1:0] k_elem;
   logic signed [ACC_W-1:0]      acc;

   assign elem_idx = elem_cnt[ELEM_W-1:0];
   assign q_elem   = $signed(q_q[elem_idx*DATA_WIDTH +: DATA_WIDTH]);
   assign k_elem   = $signed(k_q[elem_idx*DATA_WIDTH +: DATA_WIDTH]);
   assign mac_en   = (state_q == StMac) && (elem_cnt != MacEnd);

   always_comb begin
      state_d = state_q;
      k_fire  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StWaitK;
         end
         StWaitK: begin
            if (k_valid && k_ready) begin
               state_d = StMac;
               k_fire  = 1'b1;
            end
         end
         StMac: begin
            if (elem_cnt == MacEnd) state_d = StOut;
         end
         StOut: begin
            if (score_ready) state_d = (key_cnt == LastKey) ? StDone : StWaitK;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Handshake outputs are registered decodes of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         k_ready     <= 1'b0;
         score_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_ready     <= (state_d == StWaitK);
         score_valid <= (state_d == StOut);
         busy        <= (state_d != StIdle);
         done        <= (state_d == StDone);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q       <= '0;
         k_q       <= '0;
         elem_cnt  <= '0;
         key_cnt   <= '0;
         score     <= '0;
         score_idx <= '0;
      end else begin
         if ((state_q == StIdle) && start) begin
            q_q     <= q_flat;
            key_cnt <= '0;
         end
         if (k_fire) begin
            k_q      <= k_flat;
            elem_cnt <= '0;
         end
         if (mac_en) begin
            elem_cnt <= elem_cnt + 1'b1;
         end
         if ((state_q == StMac) && (state_d == StOut)) begin
            score     <= sat_shift(acc, FRAC_BITS + SCALE_SHIFT);
            score_idx <= key_cnt;
         end
         if ((state_q == StOut) && score_ready && (key_cnt != LastKey)) begin
            key_cnt <= key_cnt + 1'b1;
         end
      end
   end

   fx_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_W)
   ) u_fx_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (k_fire),
      .en    (mac_en),
      .a     (q_elem),
      .b     (k_elem),
      .acc   (acc)
   );

endmodule

// File: tb/tb_qk_score.sv
// Randomized bench for qk_score against an arithmetic dot-product reference model.
module tb_qk_score;

   localparam int DW = 16;
   localparam int ED = 64;
   localparam int SL = 8;
   localparam int VW = DW * ED;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [VW-1:0] q_flat = '0;
   logic          k_valid = 1'b0;
   logic          k_ready;
   logic [VW-1:0] k_flat = '0;
   logic          score_valid;
   logic          score_ready = 1'b0;
   logic [DW-1:0] score;
   logic [2:0]    score_idx;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   logic [VW-1:0] q_vec;
   logic [VW-1:0] k_vecs[SL];

   qk_score #(
      .DATA_WIDTH  (DW),
      .EMBED_DIM   (ED),
      .FRAC_BITS   (14),
      .SEQ_LEN     (SL),
      .SCALE_SHIFT (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .q_flat      (q_flat),
      .k_valid     (k_valid),
      .k_ready     (k_ready),
      .k_flat      (k_flat),
      .score_valid (score_valid),
      .score_ready (score_ready),
      .score       (score),
      .score_idx   (score_idx),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Real-valued meaning: sum(q*k) / 2^14 / sqrt(64), floored, clamped to int16.
   function automatic logic [DW-1:0] ref_score(input logic [VW-1:0] q, input logic [VW-1:0] k);
      longint sum = 0;
      for (int j = 0; j < ED; j++) begin
         sum += longint'($signed(q[j*DW +: DW])) * longint'($signed(k[j*DW +: DW]));
      end
      sum = sum >>> 17;
      if (sum > 32767) return 16'h7FFF;
      if (sum < -32768) return 16'h8000;
      return sum[DW-1:0];
   endfunction

   function automatic logic [VW-1:0] fill_const(input logic [DW-1:0] v);
      logic [VW-1:0] r;
      for (int j = 0; j < ED; j++) r[j*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec(input int mag);
      logic [VW-1:0] r;
      int e;
      for (int j = 0; j < ED; j++) begin
         e = int'($urandom_range(2 * mag)) - mag;
         r[j*DW +: DW] = e[DW-1:0];
      end
      return r;
   endfunction

   task automatic run_query(input string tag, input int stall_key, input int stall_len);
      int t;
      int lat;
      int kr_seen;
      int bad;
      logic [DW-1:0] exp;
      logic [DW-1:0] held_s;
      logic [2:0]    held_i;
      @(negedge clk);
      start  = 1'b1;
      q_flat = q_vec;
      @(negedge clk);
      start  = 1'b0;
      q_flat = rand_vec(32767);
      check_eq({tag, "_busy"}, busy, 1);
      for (int n = 0; n < SL; n++) begin
         t = 0;
         while (!k_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         check_eq({tag, "_k_ready"}, k_ready, 1);
         if (!k_ready) return;
         k_valid = 1'b1;
         k_flat  = k_vecs[n];
         @(negedge clk);
         // Keep k_valid high with junk data and poke start while the MAC runs.
         k_flat  = rand_vec(32767);
         start   = 1'b1;
         lat     = 0;
         kr_seen = 0;
         while (!score_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (k_ready) kr_seen++;
         end
         k_valid = 1'b0;
         start   = 1'b0;
         check_eq({tag, "_latency"}, lat, ED + 1);
         check_eq({tag, "_k_ready_in_mac"}, kr_seen, 0);
         if (!score_valid) return;
         exp = ref_score(q_vec, k_vecs[n]);
         if (n == stall_key) begin
            held_s = score;
            held_i = score_idx;
            bad    = 0;
            repeat (stall_len) begin
               @(negedge clk);
               if (score !== held_s || score_idx !== held_i || !score_valid || k_ready) bad++;
            end
            check_eq({tag, "_stall_stable"}, bad, 0);
         end
         check_eq({tag, "_score"}, score, exp);
         check_eq({tag, "_idx"}, score_idx, n);
         score_ready = 1'b1;
         @(negedge clk);
         score_ready = 1'b0;
         check_eq({tag, "_valid_drop"}, score_valid, 0);
         check_eq({tag, "_done"}, done, (n == SL - 1) ? 1 : 0);
      end
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, done, 0);
      check_eq({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      logic [VW-1:0] kv;
      int t;
      #1;
      check_eq("rst_k_ready", k_ready, 0);
      check_eq("rst_score_valid", score_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_score", score, 0);
      check_eq("rst_idx", score_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;

      q_vec = fill_const(16'h1000);
      for (int n = 0; n < SL; n++) k_vecs[n] = fill_const(16'h2000);
      check_eq("basic_model", ref_score(q_vec, k_vecs[0]), 16'h4000);
      run_query("basic", -1, 0);

      for (int n = 0; n < SL; n++) k_vecs[n] = fill_const((n % 2 == 0) ? 16'h2000 : 16'hE000);
      run_query("alt", -1, 0);

      q_vec = fill_const(16'h4000);
      for (int n = 0; n < SL; n++) k_vecs[n] = fill_const((n % 2 == 0) ? 16'h4000 : 16'hC000);
      run_query("sat", -1, 0);

      q_vec = '0;
      q_vec[DW-1:0] = 16'h4000;
      kv = fill_const(16'h7FFF);
      kv[DW-1:0] = 16'h2000;
      for (int n = 0; n < SL; n++) k_vecs[n] = kv;
      run_query("onehot", -1, 0);

      q_vec = rand_vec(4096);
      for (int n = 0; n < SL; n++) k_vecs[n] = rand_vec(int'($urandom_range(8192, 256)));
      run_query("bp", 3, 10);

      // Abort a query part-way through the MAC of its first key.
      q_vec = rand_vec(30000);
      @(negedge clk);
      start  = 1'b1;
      q_flat = q_vec;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (!k_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      k_valid = 1'b1;
      k_flat  = rand_vec(30000);
      @(negedge clk);
      k_valid = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_k_ready", k_ready, 0);
      check_eq("abort_score_valid", score_valid, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_score", score, 0);
      check_eq("abort_idx", score_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 4; r++) begin
         q_vec = rand_vec(int'($urandom_range(16384, 512)));
         for (int n = 0; n < SL; n++) k_vecs[n] = rand_vec(int'($urandom_range(16384, 512)));
         run_query("rand", int'($urandom_range(SL - 1)), int'($urandom_range(6, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/qk_score.md
Name: qk_score

Overview:
- Attention-score stage directly downstream of the Q/K/V projection block.
- Latches one query vector Q, then accepts SEQ_LEN key vectors over a valid/ready handshake.
- For each key, computes the scaled dot product (Q·K) / sqrt(EMBED_DIM) in fixed point, using one signed MAC per cycle.
- Emits one saturated score per key, with its index, to the downstream softmax stage.

Parameters:
- DATA_WIDTH, 16, bits per signed fixed-point element.
- EMBED_DIM, 64, elements per vector.
- FRAC_BITS, 14, fractional bits of every element and of the score.
- SEQ_LEN, 8, keys (scores) per query.
- SCALE_SHIFT, 3, extra right shift implementing 1/sqrt(EMBED_DIM) (log2(8) for EMBED_DIM=64).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a query; sampled only in IDLE.
- q_flat  in  DATA_WIDTH*EMBED_DIM  query vector; element j is at [j*DATA_WIDTH +: DATA_WIDTH]. Sampled on the start cycle.
- k_valid  in  1  key vector valid.
- k_ready  out  1  block can accept a key.
- k_flat  in  DATA_WIDTH*EMBED_DIM  key vector, same packing as q_flat.
- score_valid  out  1  score output valid.
- score_ready  in  1  downstream accepts score.
- score  out  DATA_WIDTH  signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS score.
- score_idx  out  $clog2(SEQ_LEN)  key index of current score.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after last score accepted.

Behaviour:
- Reset (rst_n low, async): state=IDLE; k_ready, score_valid, busy, done = 0; score, score_idx = 0; accumulator, element counter and key counter = 0; Q/K registers cleared. Reset mid-operation aborts the query; no further score is emitted.
- States: IDLE, WAIT_K, MAC, OUT, DONE.
- IDLE:
  - start=1 → latch q_flat, key counter=0, go WAIT_K.
  - start is ignored in all other states.
- WAIT_K:
  - k_ready=1 (registered output, high only in this state).
  - On k_valid&&k_ready: latch k_flat, clear accumulator and element counter, go MAC.
- MAC:
  - One element per cycle: acc <= acc + q[j]*k[j], full signed product.
  - acc width = 2*DATA_WIDTH + $clog2(EMBED_DIM); no intermediate truncation.
  - After element EMBED_DIM-1 is accumulated, go OUT.
- OUT entry:
  - score = sat(acc >>> (FRAC_BITS+SCALE_SHIFT)) to DATA_WIDTH signed.
  - Arithmetic shift, truncation toward -inf.
  - Saturation clamps to 0x7FFF/0x8000 (for DW=16).
- OUT:
  - score_valid=1; score and score_idx are held stable until score_ready.
  - On score_valid&&score_ready: if key counter==SEQ_LEN-1 go DONE, else increment the counter and go WAIT_K.
  - score_valid deasserts the cycle after acceptance.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: score_valid rises EMBED_DIM+1 cycles after the key-handshake edge.
- Throughput: one key per EMBED_DIM+3 cycles minimum.
- k_ready is low throughout MAC/OUT. Backpressure on score stalls key intake; no key is buffered.
- The latched Q is unaffected by changes on q_flat after the start cycle. The latched K is unaffected by changes on k_flat after the handshake.
- start together with rst_n deassertion: reset dominates until rst_n=1; start is then sampled normally.

Decomposition:
- Shared package attn_pkg holds:
  - state enum typedef qk_state_t (IDLE, WAIT_K, MAC, OUT, DONE);
  - the default DATA_WIDTH/EMBED_DIM/FRAC_BITS constants;
  - the saturating-shift function sat_shift shared with the softmax and context stages.
- One sub-module fx_mac holds the signed multiply-accumulate register. Its ports are clr, en, a, b and acc, with async active-low reset.

Test Plan:
- Basic dot product: Q all 0x1000 (0.25), K all 0x2000 (0.5), SEQ_LEN=1 → score=0x4000 (1.0), score_idx=0. Then done pulses exactly one cycle later than the acceptance cycle.
- Sign and sequence: 8 keys, key n all 0x2000 for even n and 0xE000 (-0.5) for odd n; Q all 0x1000. Expected scores alternate 0x4000/0xC000, score_idx runs 0..7, and done pulses once.
- Saturation: Q=K all 0x4000 (raw 8.0) → score=0x7FFF. Q all 0x4000, K all 0xC000 → score=0x8000.
- One-hot: Q element 0=0x4000 and others 0, K element 0=0x2000 and others 0x7FFF → score=0x0400 (0.0625). This checks that only the aligned products contribute.
- Backpressure and handshake:
  - hold score_ready=0 for 10 cycles → score/score_idx stable, k_ready=0;
  - k_valid held high during MAC → no extra key consumed;
  - latency from key handshake to score_valid is exactly 65 cycles.
- Reset mid-MAC: drop rst_n at element 30 → all outputs 0 immediately. Then a new start runs a full query and produces correct scores without residue from the aborted one.
